// File: rtl/lcd_ctrl.sv
// HD44780-style 4-bit write-only LCD controller: power-up init sequence, then
// byte writes split into two E-strobed nibbles with per-command settle waits.
module lcd_ctrl #(
  parameter int P_PWRUP      = 750000,
  parameter int P_INIT_LONG  = 205000,
  parameter int P_INIT_SHORT = 5000,
  parameter int P_CMD        = 2000,
  parameter int P_CLR        = 82000,
  parameter int P_SU         = 2,
  parameter int P_E          = 12,
  parameter int P_GAP        = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] sf_d
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int P_MAX = max2(max2(max2(P_PWRUP, P_INIT_LONG), max2(P_INIT_SHORT, P_CMD)),
                              max2(max2(P_CLR, P_SU), max2(P_E, P_GAP)));
  localparam int CW = $clog2(P_MAX + 1);

  // Counter reload values: a state loaded with N-1 lasts exactly N cycles.
  localparam logic [CW-1:0] L_PWRUP      = CW'(P_PWRUP - 1);
  localparam logic [CW-1:0] L_INIT_LONG  = CW'(P_INIT_LONG - 1);
  localparam logic [CW-1:0] L_INIT_SHORT = CW'(P_INIT_SHORT - 1);
  localparam logic [CW-1:0] L_CMD        = CW'(P_CMD - 1);
  localparam logic [CW-1:0] L_CLR        = CW'(P_CLR - 1);
  localparam logic [CW-1:0] L_SU         = CW'(P_SU - 1);
  localparam logic [CW-1:0] L_E          = CW'(P_E - 1);
  localparam logic [CW-1:0] L_GAP        = CW'(P_GAP - 1);

  typedef enum logic [3:0] {
    PWRUP, INIT_SU, INIT_E, INIT_WAIT, IDLE,
    SU_HI, E_HI, GAP, SU_LO, E_LO, WAIT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_ld_val, init_wait_len;
  logic          cnt_ld, cnt_done, is_clr, accept;
  logic [1:0]    step, step_nx;
  logic          rs_q, rs_nx;
  logic [7:0]    data_q, data_nx;
  logic          lcd_rs_nx, lcd_e_nx;
  logic [3:0]    sf_d_nx;

  assign cnt_done = (cnt == '0);
  assign accept   = (state == IDLE) && wr_valid;
  assign is_clr   = !rs_q && (data_q <= 8'h03);
  assign lcd_rw   = 1'b0;

  always_comb begin
    unique case (step)
      2'd0:    init_wait_len = L_INIT_LONG;
      2'd1:    init_wait_len = L_INIT_SHORT;
      default: init_wait_len = L_CMD;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    unique case (state)
      PWRUP:     if (cnt_done) begin state_nx = INIT_SU;   cnt_ld = 1'b1; cnt_ld_val = L_SU; end
      INIT_SU:   if (cnt_done) begin state_nx = INIT_E;    cnt_ld = 1'b1; cnt_ld_val = L_E; end
      INIT_E:    if (cnt_done) begin state_nx = INIT_WAIT; cnt_ld = 1'b1; cnt_ld_val = init_wait_len; end
      INIT_WAIT: if (cnt_done) begin
        if (step == 2'd3) begin
          state_nx = IDLE;
        end else begin
          state_nx = INIT_SU; cnt_ld = 1'b1; cnt_ld_val = L_SU;
        end
      end
      IDLE:      if (wr_valid) begin state_nx = SU_HI;     cnt_ld = 1'b1; cnt_ld_val = L_SU; end
      SU_HI:     if (cnt_done) begin state_nx = E_HI;      cnt_ld = 1'b1; cnt_ld_val = L_E; end
      E_HI:      if (cnt_done) begin state_nx = GAP;       cnt_ld = 1'b1; cnt_ld_val = L_GAP; end
      GAP:       if (cnt_done) begin state_nx = SU_LO;     cnt_ld = 1'b1; cnt_ld_val = L_SU; end
      SU_LO:     if (cnt_done) begin state_nx = E_LO;      cnt_ld = 1'b1; cnt_ld_val = L_E; end
      E_LO:      if (cnt_done) begin
        state_nx = WAIT; cnt_ld = 1'b1; cnt_ld_val = is_clr ? L_CLR : L_CMD;
      end
      WAIT:      if (cnt_done) state_nx = IDLE;
      default:   begin state_nx = PWRUP; cnt_ld = 1'b1; cnt_ld_val = L_PWRUP; end
    endcase
  end

  always_comb begin
    step_nx = step;
    if (state == INIT_WAIT && cnt_done) step_nx = step + 2'd1;
    rs_nx   = accept ? wr_rs   : rs_q;
    data_nx = accept ? wr_data : data_q;
  end

  // Pins are decoded from next-state values and registered, so they carry
  // exactly the timing of the state they belong to without decode glitches.
  always_comb begin
    lcd_e_nx  = 1'b0;
    lcd_rs_nx = 1'b0;
    sf_d_nx   = '0;
    unique case (state_nx)
      INIT_SU, INIT_E, INIT_WAIT: begin
        sf_d_nx  = (step_nx == 2'd3) ? 4'h2 : 4'h3;
        lcd_e_nx = (state_nx == INIT_E);
      end
      SU_HI, E_HI, GAP: begin
        sf_d_nx   = data_nx[7:4];
        lcd_rs_nx = rs_nx;
        lcd_e_nx  = (state_nx == E_HI);
      end
      SU_LO, E_LO, WAIT: begin
        sf_d_nx   = data_nx[3:0];
        lcd_rs_nx = rs_nx;
        lcd_e_nx  = (state_nx == E_LO);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PWRUP;
      cnt    <= L_PWRUP;
      step   <= 2'd0;
      rs_q   <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      step   <= step_nx;
      rs_q   <= rs_nx;
      data_q <= data_nx;
      if (cnt_ld)         cnt <= cnt_ld_val;
      else if (!cnt_done) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      sf_d      <= '0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      lcd_e    <= lcd_e_nx;
      lcd_rs   <= lcd_rs_nx;
      sf_d     <= sf_d_nx;
      wr_ready <= (state_nx == IDLE);
      if (state_nx == IDLE) init_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters; every
// expected delay and nibble below is derived by hand from those parameters.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] sf_d;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_ctrl #(
    .P_PWRUP(20), .P_INIT_LONG(8), .P_INIT_SHORT(4), .P_CMD(6),
    .P_CLR(30), .P_SU(1), .P_E(3), .P_GAP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_ready(wr_ready), .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .sf_d(sf_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for an E rise (delay counted in cycles from the current sample),
  // then checks nibble, rs, pulse width, stability and hold after the fall.
  task automatic pulse(input string tag, input int exp_dly, input logic [3:0] nib, input logic rs);
    int n = 0;
    int w = 1;
    bit stable = 1'b1;
    while (!lcd_e && n < 200) begin tick(); n++; end
    check({tag, " rise delay"}, n, exp_dly);
    check({tag, " sf_d"}, int'(sf_d), int'(nib));
    check({tag, " lcd_rs"}, int'(lcd_rs), int'(rs));
    while (lcd_e && w < 200) begin
      tick();
      if (lcd_e) begin
        w++;
        if (sf_d != nib || lcd_rs != rs) stable = 1'b0;
      end
    end
    check({tag, " e width"}, w, 3);
    check({tag, " stable"}, int'(stable), 1);
    check({tag, " sf_d hold"}, int'(sf_d), int'(nib));
    check({tag, " rs hold"}, int'(lcd_rs), int'(rs));
  endtask

  task automatic wait_ready(input string tag, input int exp);
    int n = 0;
    while (!wr_ready && n < 200) begin tick(); n++; end
    check({tag, " ready delay"}, n, exp);
  endtask

  // Called on the sample right after acceptance (first setup cycle).
  task automatic check_xfer(input string tag, input logic [7:0] d, input logic rs, input int exp_wait);
    check({tag, " ready low"}, int'(wr_ready), 0);
    pulse({tag, " hi"}, 1, d[7:4], rs);
    pulse({tag, " lo"}, 3, d[3:0], rs);
    wait_ready(tag, exp_wait);
    check({tag, " idle sf_d"}, int'(sf_d), 0);
    check({tag, " idle rs"}, int'(lcd_rs), 0);
  endtask

  task automatic do_write(input string tag, input logic rs, input logic [7:0] d, input int exp_wait);
    wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    tick();
    wr_valid = 1'b0; wr_rs = ~rs; wr_data = ~d;
    check_xfer(tag, d, rs, exp_wait);
  endtask

  task automatic run_init(input string tag);
    rst_n = 1'b1;
    pulse({tag, " n0"}, 21, 4'h3, 1'b0);
    pulse({tag, " n1"}, 9, 4'h3, 1'b0);
    pulse({tag, " n2"}, 5, 4'h3, 1'b0);
    pulse({tag, " n3"}, 7, 4'h2, 1'b0);
    check({tag, " done early"}, int'(init_done), 0);
    wait_ready(tag, 6);
    check({tag, " init_done"}, int'(init_done), 1);
    check({tag, " idle sf_d"}, int'(sf_d), 0);
  endtask

  initial begin
    int n;
    int e_cnt;
    rst_n = 1'b0; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = '0;
    tick(); tick();
    check("rst lcd_e", int'(lcd_e), 0);
    check("rst sf_d", int'(sf_d), 0);
    check("rst lcd_rs", int'(lcd_rs), 0);
    check("rst lcd_rw", int'(lcd_rw), 0);
    check("rst wr_ready", int'(wr_ready), 0);
    check("rst init_done", int'(init_done), 0);

    run_init("init");

    do_write("data41", 1'b1, 8'h41, 6);
    do_write("clr01", 1'b0, 8'h01, 30);
    do_write("cmd28", 1'b0, 8'h28, 6);
    do_write("home03", 1'b0, 8'h03, 30);
    do_write("cmd04", 1'b0, 8'h04, 6);
    do_write("data03", 1'b1, 8'h03, 6);

    // Back-to-back: valid held, inputs switch to the second byte mid-transfer.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hA5;
    tick();
    wr_rs = 1'b0; wr_data = 8'h3C;
    check_xfer("b2b first", 8'hA5, 1'b1, 6);
    tick();
    wr_valid = 1'b0; wr_data = 8'h00;
    check_xfer("b2b second", 8'h3C, 1'b0, 6);
    e_cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (lcd_e) e_cnt++; end
    check("b2b no dup", e_cnt, 0);

    // wr_valid pulsed while the upper nibble strobe is high.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h5A;
    tick();
    wr_valid = 1'b0; wr_data = 8'h00;
    tick();
    check("ign in E_HI", int'(lcd_e), 1);
    check("ign hi sf_d", int'(sf_d), 5);
    wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    n = 0;
    while (lcd_e && n < 50) begin tick(); n++; end
    check("ign hi fall", n, 2);
    pulse("ign lo", 3, 4'hA, 1'b1);
    wait_ready("ign", 6);
    e_cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (lcd_e) e_cnt++; end
    check("ign no extra", e_cnt, 0);

    // Reset asserted during the lower-nibble strobe.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    tick();
    wr_valid = 1'b0;
    n = 0;
    while (!(lcd_e && sf_d == 4'h1) && n < 40) begin tick(); n++; end
    check("rst E_LO reached", n, 7);
    rst_n = 1'b0;
    #1;
    check("mid rst lcd_e", int'(lcd_e), 0);
    check("mid rst sf_d", int'(sf_d), 0);
    check("mid rst lcd_rs", int'(lcd_rs), 0);
    check("mid rst init_done", int'(init_done), 0);
    check("mid rst wr_ready", int'(wr_ready), 0);
    tick(); tick();
    check("held rst lcd_e", int'(lcd_e), 0);
    run_init("reinit");
    do_write("post data", 1'b1, 8'h7E, 6);
    check("lcd_rw end", int'(lcd_rw), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter P_PWRUP, 750000, power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter P_INIT_LONG, 205000, wait after first init nibble (4.1 ms).
REQ-003 SHALL have parameter P_INIT_SHORT, 5000, wait after second init nibble (100 us).
REQ-004 SHALL have parameter P_CMD, 2000, post-write wait for normal commands and data (40 us).
REQ-005 SHALL have parameter P_CLR, 82000, post-write wait for clear/home commands (1.64 ms).
REQ-006 SHALL have parameter P_SU, 2, sf_d/lcd_rs setup cycles before lcd_e rises.
REQ-007 SHALL have parameter P_E, 12, lcd_e high cycles.
REQ-008 SHALL have parameter P_GAP, 50, cycles between upper-nibble and lower-nibble phases.
REQ-009 SHALL have ports: clk  in  1  system clock, rising edge; all state on this single clock.
REQ-010 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-011 SHALL have ports: wr_valid  in  1  host write request; wr_rs  in  1  0=command, 1=data; wr_data  in  8  byte to write.
REQ-012 SHALL have ports: wr_ready  out  1  controller accepts a byte this cycle; init_done  out  1  init sequence complete.
REQ-013 SHALL have ports: lcd_rs  out  1; lcd_rw  out  1; lcd_e  out  1; sf_d  out  4  LCD 4-bit bus (board pins sf_d[11:8]).

Function
REQ-014 SHALL tie lcd_rw to 0 permanently; write-only, no busy-flag read.
REQ-015 SHALL implement states PWRUP, INIT_SU, INIT_E, INIT_WAIT, IDLE, SU_HI, E_HI, GAP, SU_LO, E_LO, WAIT; each timed state lasts exactly its parameter count of cycles via one down-counter.
REQ-016 SHALL run init after reset: PWRUP (P_PWRUP) -> nibble 0x3, wait P_INIT_LONG -> 0x3, wait P_INIT_SHORT -> 0x3, wait P_CMD -> 0x2, wait P_CMD -> IDLE; each nibble is INIT_SU (P_SU) then INIT_E (P_E) with lcd_rs=0.
REQ-017 SHALL set init_done=1 on entering IDLE the first time and hold it until reset.
REQ-018 SHALL assert wr_ready only in IDLE; a transfer occurs when wr_valid && wr_ready on a rising edge; wr_rs/wr_data captured there, later input changes ignored.
REQ-019 SHALL ignore wr_valid outside IDLE (no queuing); host must hold wr_valid until wr_ready.
REQ-020 SHALL, after a transfer: SU_HI (sf_d=data[7:4], lcd_rs=rs, P_SU) -> E_HI (lcd_e=1, P_E) -> GAP (lcd_e=0, P_GAP) -> SU_LO (sf_d=data[3:0], P_SU) -> E_LO (lcd_e=1, P_E) -> WAIT -> IDLE.
REQ-021 SHALL use P_CLR in WAIT when rs=0 and data<=0x03 (clear/home), else P_CMD.
REQ-022 SHALL hold sf_d and lcd_rs stable throughout each E pulse and for the following gap/wait; sf_d and lcd_rs return to 0 in IDLE.
REQ-023 SHALL assert wr_ready in the same cycle WAIT ends, allowing back-to-back writes with no extra idle cycle.

Reset
REQ-024 SHALL, on rst_n=0 at any time including mid-transfer or mid-init, immediately force state PWRUP, lcd_e=0, lcd_rs=0, lcd_rw=0, sf_d=0, wr_ready=0, init_done=0, counter reloaded; a partial write is discarded.
REQ-025 SHALL restart the full init sequence after every rst_n release.

Verification (P_PWRUP=20, P_INIT_LONG=8, P_INIT_SHORT=4, P_CMD=6, P_CLR=30, P_SU=1, P_E=3, P_GAP=2)
REQ-026 SHALL check init: release rst_n -> first lcd_e rise 21 cycles later, four E pulses of 3 cycles with sf_d=3,3,3,2 and lcd_rs=0, then init_done=1 and wr_ready=1.
REQ-027 SHALL check data write: wr_rs=1, wr_data=0x41 -> pulses sf_d=4 then 1, lcd_rs=1, pulses 3 cycles, 2-cycle gap, wr_ready back after 6-cycle WAIT.
REQ-028 SHALL check clear: wr_rs=0, wr_data=0x01 -> sf_d=0 then 1, lcd_rs=0, WAIT 30 cycles; 0x28 command -> WAIT 6 cycles.
REQ-029 SHALL check back-to-back: wr_valid held with two bytes -> second accepted the cycle wr_ready reasserts, no dropped or duplicated nibble.
REQ-030 SHALL check wr_valid pulsed during E_HI -> ignored, no extra transfer.
REQ-031 SHALL check rst_n low during E_LO -> lcd_e=0, sf_d=0, init_done=0 immediately; full init repeats after release.
